// File: rtl/seg7_bcd_scan_display.sv
// rtl/seg7_bcd_scan_display.sv - binary-in, double-dabble BCD, multiplexed 7-segment scanner
// Optional flashing display enabled by defining SEG7_BLINK_EN.
module seg7_bcd_scan_display #(
  parameter int NUM_DIGITS  = 8,
  parameter int BIN_WIDTH   = 16,
  parameter int REFRESH_DIV = 100_000,
  parameter int BLINK_DIV   = 25
) (
  input  logic                  CLK100MHZ,
  input  logic                  reset,
  input  logic [BIN_WIDTH-1:0]  value,
  input  logic                  value_valid,
  output logic                  value_ready,
  input  logic                  blank_lz,
`ifdef SEG7_BLINK_EN
  input  logic                  blink,
`endif
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] an
);

  localparam int NIB    = NUM_DIGITS + 1;
  localparam int ACC_W  = NIB * 4;
  localparam int DISP_W = NUM_DIGITS * 4;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int REF_W  = $clog2(REFRESH_DIV);
  localparam int BIT_W  = $clog2(BIN_WIDTH + 1);

  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [REF_W-1:0]      LAST_REF = REF_W'(REFRESH_DIV - 1);
  localparam logic [BIT_W-1:0]      LAST_BIT = BIT_W'(BIN_WIDTH - 1);
  localparam logic [NUM_DIGITS-1:0] AN_ONE   = NUM_DIGITS'(1);

  localparam logic [6:0] SEG_DASH  = 7'b111_1110;
  localparam logic [6:0] SEG_BLANK = 7'b111_1111;

  generate
    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
      $error("NUM_DIGITS out of range");
    end
    if (REFRESH_DIV < 2 || BLINK_DIV < 1) begin : g_bad_div
      $error("REFRESH_DIV must be >= 2 and BLINK_DIV >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_LOAD} state_t;

  state_t                 state, state_next;
  logic [BIN_WIDTH-1:0]   bin_sr;
  logic [ACC_W-1:0]       acc, acc_adj;
  logic                   lost_bit;
  logic [BIT_W-1:0]       bit_cnt;
  logic [DISP_W-1:0]      disp;
  logic                   ovf;
  logic                   accept;

  logic [REF_W-1:0]       ref_cnt;
  logic [IDX_W-1:0]       idx, idx_next;
  logic                   ref_wrap;
  logic [NUM_DIGITS-1:0]  an_q;
  logic [NUM_DIGITS-1:0]  lz;
  logic                   upper_zero;
  logic [3:0]             digit;
  logic [6:0]             seg_next;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    case (d)
      4'd0:    bcd_to_seg = 7'b000_0001;
      4'd1:    bcd_to_seg = 7'b100_1111;
      4'd2:    bcd_to_seg = 7'b001_0010;
      4'd3:    bcd_to_seg = 7'b000_0110;
      4'd4:    bcd_to_seg = 7'b100_1100;
      4'd5:    bcd_to_seg = 7'b010_0100;
      4'd6:    bcd_to_seg = 7'b010_0000;
      4'd7:    bcd_to_seg = 7'b000_1111;
      4'd8:    bcd_to_seg = 7'b000_0000;
      4'd9:    bcd_to_seg = 7'b000_0100;
      default: bcd_to_seg = 7'b111_1111;
    endcase
  endfunction

  assign accept = value_valid && value_ready;

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept) state_next = S_CONV;
      S_CONV:  if (bit_cnt == LAST_BIT) state_next = S_LOAD;
      S_LOAD:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < NIB; i++) begin
      if (acc[i*4 +: 4] >= 4'd5) acc_adj[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
    end
  end

  // Bits pushed past the guard nibble are kept sticky so very large values still read as overflow.
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      bin_sr      <= '0;
      acc         <= '0;
      lost_bit    <= 1'b0;
      bit_cnt     <= '0;
      disp        <= '0;
      ovf         <= 1'b0;
      value_ready <= 1'b1;
    end else begin
      value_ready <= (state_next == S_IDLE);
      case (state)
        S_IDLE: begin
          if (accept) begin
            bin_sr   <= value;
            acc      <= '0;
            lost_bit <= 1'b0;
            bit_cnt  <= '0;
          end
        end
        S_CONV: begin
          bin_sr   <= bin_sr << 1;
          acc      <= {acc_adj[ACC_W-2:0], bin_sr[BIN_WIDTH-1]};
          lost_bit <= lost_bit | acc_adj[ACC_W-1];
          bit_cnt  <= bit_cnt + 1'b1;
        end
        S_LOAD: begin
          disp <= acc[DISP_W-1:0];
          ovf  <= lost_bit | (acc[ACC_W-1 -: 4] != 4'd0);
        end
        default: ;
      endcase
    end
  end

  assign ref_wrap = (ref_cnt == LAST_REF);
  assign idx_next = (idx == LAST_IDX) ? '0 : idx + 1'b1;

  // lz[k]: digit k and every digit above it are zero.
  always_comb begin
    lz         = '0;
    upper_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      upper_zero = upper_zero && (disp[k*4 +: 4] == 4'd0);
      lz[k]      = upper_zero;
    end
  end

  always_comb begin
    digit = disp[int'(idx_next)*4 +: 4];
    if (ovf)                                          seg_next = SEG_DASH;
    else if (blank_lz && idx_next != '0 && lz[idx_next]) seg_next = SEG_BLANK;
    else                                              seg_next = bcd_to_seg(digit);
  end

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      ref_cnt <= '0;
      idx     <= '0;
      an_q    <= ~AN_ONE;
      seg     <= 7'b000_0001;
    end else if (ref_wrap) begin
      ref_cnt <= '0;
      idx     <= idx_next;
      an_q    <= ~(AN_ONE << idx_next);
      seg     <= seg_next;
    end else begin
      ref_cnt <= ref_cnt + 1'b1;
    end
  end

  assign dp = 1'b1;

`ifdef SEG7_BLINK_EN
  localparam int              BL_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BL_W-1:0] LAST_BL = BL_W'(BLINK_DIV - 1);

  logic [BL_W-1:0] blink_cnt;
  logic            blink_off;
  logic            frame_wrap;

  assign frame_wrap = ref_wrap && (idx == LAST_IDX);

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else if (!blink) begin
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else if (frame_wrap) begin
      if (blink_cnt == LAST_BL) begin
        blink_cnt <= '0;
        blink_off <= ~blink_off;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  assign an = an_q | {NUM_DIGITS{blink & blink_off}};
`else
  assign an = an_q;
`endif

endmodule

// File: tb/tb_seg7_bcd_scan_display.sv
// tb/tb_seg7_bcd_scan_display.sv - self-checking bench for seg7_bcd_scan_display
// Arithmetic reference model for the 8-digit instance plus literal checks on both instances.
module tb_seg7_bcd_scan_display;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] value_a = '0, value_b = '0;
  logic        valid_a = 1'b0, valid_b = 1'b0;
  logic        blank_a = 1'b0, blank_b = 1'b0;
  logic        blink = 1'b0;
  logic        ready_a, ready_b, dp_a, dp_b;
  logic [6:0]  seg_a, seg_b;
  logic [7:0]  an_a;
  logic [2:0]  an_b;

  int compared = 0;
  int mismatched = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  seg7_bcd_scan_display #(.NUM_DIGITS(8), .BIN_WIDTH(16), .REFRESH_DIV(4), .BLINK_DIV(2)) dut_a (
    .CLK100MHZ(clk), .reset(rst), .value(value_a), .value_valid(valid_a), .value_ready(ready_a),
    .blank_lz(blank_a),
`ifdef SEG7_BLINK_EN
    .blink(blink),
`endif
    .seg(seg_a), .dp(dp_a), .an(an_a));

  seg7_bcd_scan_display #(.NUM_DIGITS(3), .BIN_WIDTH(16), .REFRESH_DIV(4), .BLINK_DIV(2)) dut_b (
    .CLK100MHZ(clk), .reset(rst), .value(value_b), .value_valid(valid_b), .value_ready(ready_b),
    .blank_lz(blank_b),
`ifdef SEG7_BLINK_EN
    .blink(1'b0),
`endif
    .seg(seg_b), .dp(dp_b), .an(an_b));

  localparam logic [6:0] G_BLANK = 7'b111_1111;
  localparam logic [6:0] G_DASH  = 7'b111_1110;
  logic [6:0] enc [10] = '{7'b000_0001, 7'b100_1111, 7'b001_0010, 7'b000_0110, 7'b100_1100,
                           7'b010_0100, 7'b010_0000, 7'b000_1111, 7'b000_0000, 7'b000_0100};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // What digit k of a decimal number v looks like on an nd-digit display.
  function automatic logic [6:0] glyph(input int v, input int k, input bit blz, input int nd);
    int p = 1;
    int lim = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    for (int i = 0; i < nd; i++) lim = lim * 10;
    if (v > lim - 1) return G_DASH;
    if (blz && k > 0 && v < p) return G_BLANK;
    return enc[(v / p) % 10];
  endfunction

  // Reference model of instance A: time-slot position, display value and handshake.
  int         m_tick, m_idx, m_disp, m_pend, m_cd;
  bit         m_ready;
  logic [7:0] m_an;
  logic [6:0] m_seg;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_tick = 0; m_idx = 0; m_disp = 0; m_pend = 0; m_cd = 0; m_ready = 1'b1;
      m_an = 8'hFE; m_seg = glyph(0, 0, 1'b0, 8);
    end else begin
      m_tick = m_tick + 1;
      if (m_tick == 4) begin
        m_tick = 0;
        m_idx  = (m_idx + 1) % 8;
        m_an   = ~(8'd1 << m_idx);
        m_seg  = glyph(m_disp, m_idx, blank_a, 8);
      end
      if (m_cd > 0) begin
        m_cd = m_cd - 1;
        if (m_cd == 0) begin
          m_disp  = m_pend;
          m_ready = 1'b1;
        end
      end else if (valid_a && m_ready) begin
        m_pend  = int'(value_a);
        m_cd    = 17;
        m_ready = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      check("model_an",    32'(an_a),    32'(m_an));
      check("model_seg",   32'(seg_a),   32'(m_seg));
      check("model_ready", 32'(ready_a), 32'(m_ready));
      check("model_dp",    32'(dp_a),    32'd1);
    end
  end

  logic [6:0] got [8];

  task automatic collect(input int which);
    for (int k = 0; k < 8; k++) got[k] = 7'h00;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      for (int k = 0; k < 8; k++) begin
        if (which == 0 && an_a[k] == 1'b0) got[k] = seg_a;
        if (which == 1 && k < 3 && an_b[k] == 1'b0) got[k] = seg_b;
      end
    end
  endtask

  task automatic send(input int which, input logic [15:0] v);
    @(negedge clk);
    if (which == 0) begin value_a = v; valid_a = 1'b1; end
    else            begin value_b = v; valid_b = 1'b1; end
    @(negedge clk);
    valid_a = 1'b0;
    valid_b = 1'b0;
  endtask

  task automatic wait_ready(input int which, output int n);
    n = 0;
    while ((which == 0 ? ready_a : ready_b) == 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("ready_timeout", 32'(n), 32'd0);
  endtask

  task automatic expect_frame(input string tag, input logic [6:0] e0, e1, e2, e3, e4, e5, e6, e7, input int nd);
    logic [6:0] e [8];
    e = '{e0, e1, e2, e3, e4, e5, e6, e7};
    for (int k = 0; k < nd; k++) check($sformatf("%s_d%0d", tag, k), 32'(got[k]), 32'(e[k]));
  endtask

  int n;

  initial begin
    #2 rst = 1'b1;
    #20;
    @(negedge clk);
    rst = 1'b0;
    cmp_en = 1'b1;
    check("rst_an",    32'(an_a),    32'h0000_00FE);
    check("rst_seg",   32'(seg_a),   32'(7'b000_0001));
    check("rst_ready", 32'(ready_a), 32'd1);
    check("rst_dp",    32'(dp_a),    32'd1);
    check("model_pin_zero", 32'(glyph(0, 0, 1'b1, 8)), 32'(7'b000_0001));
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("an_slot0_hold", 32'(an_a), 32'h0000_00FE);
    @(posedge clk);
    @(negedge clk);
    check("an_slot1", 32'(an_a), 32'h0000_00FD);
    check("b_an_slot1", 32'(an_b), 32'(3'b101));
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("b_an_slot2", 32'(an_b), 32'(3'b011));
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("b_an_wrap", 32'(an_b), 32'(3'b110));

    blank_a = 1'b1;
    send(0, 16'd1234);
    wait_ready(0, n);
    check("ready_low_cycles", 32'(n), 32'd17);
    repeat (32) @(negedge clk);
    collect(0);
    expect_frame("v1234", 7'b100_1100, 7'b000_0110, 7'b001_0010, 7'b100_1111,
                 G_BLANK, G_BLANK, G_BLANK, G_BLANK, 8);
    check("model_pin_1234_d3", 32'(glyph(1234, 3, 1'b1, 8)), 32'(7'b100_1111));

    blank_a = 1'b0;
    send(0, 16'd1005);
    wait_ready(0, n);
    repeat (32) @(negedge clk);
    collect(0);
    expect_frame("v1005", 7'b010_0100, 7'b000_0001, 7'b000_0001, 7'b100_1111,
                 7'b000_0001, 7'b000_0001, 7'b000_0001, 7'b000_0001, 8);

    blank_a = 1'b1;
    @(negedge clk);
    value_a = 16'd42; valid_a = 1'b1;
    @(negedge clk);
    value_a = 16'd7;
    repeat (14) @(negedge clk);
    valid_a = 1'b0;
    wait_ready(0, n);
    repeat (32) @(negedge clk);
    collect(0);
    expect_frame("hold42", 7'b001_0010, 7'b100_1100, G_BLANK, G_BLANK,
                 G_BLANK, G_BLANK, G_BLANK, G_BLANK, 8);

    blank_b = 1'b0;
    send(1, 16'd999);
    wait_ready(1, n);
    repeat (16) @(negedge clk);
    collect(1);
    expect_frame("b999", 7'b000_0100, 7'b000_0100, 7'b000_0100, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 3);
    send(1, 16'd1000);
    wait_ready(1, n);
    repeat (16) @(negedge clk);
    collect(1);
    expect_frame("b1000", G_DASH, G_DASH, G_DASH, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 3);
    check("model_pin_ovf", 32'(glyph(1000, 0, 1'b0, 3)), 32'(G_DASH));

`ifdef SEG7_BLINK_EN
    begin
      int off_all, off_first;
      logic [7:0] prev;
      cmp_en = 1'b0;
      prev = an_a;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (prev == 8'h7F && an_a == 8'hFE) break;
        prev = an_a;
      end
      blink = 1'b1;
      off_all = 0; off_first = 0;
      for (int j = 0; j < 256; j++) begin
        if (an_a == 8'hFF) begin
          off_all++;
          if (j < 64) off_first++;
        end
        @(negedge clk);
      end
      blink = 1'b0;
      check("blink_off_cycles", 32'(off_all), 32'd128);
      check("blink_on_first", 32'(off_first), 32'd0);
      @(negedge clk);
      cmp_en = 1'b1;
    end
`endif

    send(0, 16'd500);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midconv_ready", 32'(ready_a), 32'd1);
    check("midconv_an",    32'(an_a),    32'h0000_00FE);
    check("midconv_seg",   32'(seg_a),   32'(7'b000_0001));
    @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout compared=%0d expected=finish", compared);
    $fatal(1);
  end

endmodule
